// File: rtl/shift_pkg.sv
// Shared encodings, state type and default sizes for the multi-cycle shifter.
package shift_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRA  = 2'b01;
   localparam logic [1:0] OP_SRL  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/shift_stage.sv
// Single shared shift stage: shifts by 2^k when enabled, otherwise passes data through.
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] k,
   input  logic               en,
   input  logic [1:0]         op,
   output logic [WIDTH-1:0]   shifted
);

   logic [SHAMT_W-1:0] amt;

   always_comb begin
      amt = SHAMT_W'(1) << k;
      // NOTE: defaulting every output first in always_comb means no path leaves it unassigned, so no latch.
      shifted = data;
      if (en) begin
         case (op)
            OP_SLL:  shifted = data << amt;
            OP_SRA:  shifted = $signed(data) >>> amt;
            OP_SRL:  shifted = data >> amt;
            default: shifted = data;
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one shared stage walked from 2^(SHAMT_W-1) down to 2^0,
// with valid/ready handshakes on both sides.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_err,
   output logic               busy
);

   localparam logic [SHAMT_W-1:0] STAGE_TOP = SHAMT_W'(SHAMT_W - 1);

   state_e             state_q, state_d;
   logic [SHAMT_W-1:0] stage_q, stage_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic [1:0]         op_q, op_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_err_q, out_err_d;

   logic               stage_en;
   logic [WIDTH-1:0]   stage_out;
   logic               accept;

   assign stage_en = |(shamt_q & (SHAMT_W'(1) << stage_q));

   shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_stage (
      .data    (data_q),
      .k       (stage_q),
      .en      (stage_en),
      .op      (op_q),
      .shifted (stage_out)
   );

   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      data_d      = data_q;
      shamt_d     = shamt_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;

      case (state_q)
         IDLE: ;
         SHIFT: begin
            data_d  = stage_out;
            stage_d = stage_q - SHAMT_W'(1);
            if (stage_q == '0) begin
               state_d     = DONE;
               stage_d     = STAGE_TOP;
               out_valid_d = 1'b1;
               out_data_d  = stage_out;
               out_err_d   = (op_q == OP_RSVD);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept overrides the DONE->IDLE exit so back-to-back requests skip IDLE.
      if (accept) begin
         state_d = SHIFT;
         stage_d = STAGE_TOP;
         data_d  = in_data;
         shamt_d = in_shamt;
         op_d    = in_op;
      end
   end

   // NOTE: the datapath holding registers are reset as well, since out_data must read 0 straight out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         stage_q     <= STAGE_TOP;
         data_q      <= '0;
         shamt_q     <= '0;
         op_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
         state_q     <= state_d;
         stage_q     <= stage_d;
         data_q      <= data_d;
         shamt_q     <= shamt_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for the ALU shift path. It accepts one operand, a shift amount and a shift type over a valid/ready handshake. It then steps a single shared shift stage through the 16/8/4/2/1 positions, one position per cycle, and returns the result over a second valid/ready handshake. It sits between the execute-stage issue logic and the writeback mux. It replaces the fully combinational five-stage barrel shifter on area-constrained builds.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, minimum 2.
SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  controller can accept a request this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift amount, unsigned
in_op  input  2  shift type: 00 SLL, 01 SRA, 10 SRL, 11 reserved
out_valid  output  1  result present
out_ready  input  1  consumer can take the result
out_data  output  WIDTH  shifted result
out_err  output  1  the request used reserved op 11; valid only with out_valid
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, stage index=SHAMT_W-1, in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0. Internal operand, shamt and op registers are cleared to 0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The output is combinational from state and out_ready only; it does not depend on in_valid.
- Accept: a request is accepted on an edge where in_valid & in_ready. On that edge the controller latches in_data, in_shamt and in_op, sets stage=SHAMT_W-1 and moves to SHIFT. in_* are don't-care afterwards.
- SHIFT: on each edge the controller applies the stage for index k.
  - If shamt[k]=1, shift by 2^k: SLL zero-fills the LSBs; SRL zero-fills the MSBs; SRA replicates operand bit WIDTH-1 into the vacated MSBs.
  - If shamt[k]=0, the register holds its value.
  - k then decrements. The edge that applies k=0 moves the state to DONE and sets out_valid=1.
- Latency is fixed and independent of shamt. out_valid rises exactly SHAMT_W edges (5 by default) after the accept edge. There is no early exit for zero bits.
- Op 11: the operand passes through unchanged with the same fixed latency, and out_err=1 alongside out_valid.
- DONE: out_valid=1. out_data and out_err hold stable until the edge where out_ready=1.
  - On that edge, with in_valid=1, the next request is accepted (back-to-back) and the state goes to SHIFT.
  - On that edge, with in_valid=0, the state goes to IDLE and out_valid=0.
- Throughput: one result every SHAMT_W+1 cycles when out_ready is held high.
- out_ready asserted while not in DONE has no effect.
- out_data holds the last result after out_valid falls. The only exception is reset, which clears it.
- Reset mid-operation (reset_n asserted in SHIFT or DONE): the in-flight result is discarded and no out_valid pulse is produced. After reset_n deasserts, the controller accepts a new request on the first edge.
- shamt=0 returns the operand unchanged. shamt=WIDTH-1 is the maximum; no value of shamt is out of range.

Decomposition:
- Shared package shift_pkg contains:
  - op encodings: OP_SLL=2'b00, OP_SRA=2'b01, OP_SRL=2'b10, OP_RSVD=2'b11;
  - state enum: IDLE, SHIFT, DONE;
  - default WIDTH and SHAMT_W constants.
- One natural sub-module, shift_stage: combinational, with inputs data[WIDTH-1:0], k[SHAMT_W-1:0], en and op, and output data shifted by 2^k per op (pass-through when en=0 or op=11).
- shift_sequencer contains only the FSM, the stage counter, the holding registers and the handshake logic.

Test Plan:
- SRA 0x80000000 by 16, out_ready=1 -> out_data=0xFFFF8000, out_err=0; out_valid rises exactly 5 edges after accept.
- SRL 0x80000000 by 31 -> 0x00000001. SLL 0x00000001 by 31 -> 0x80000000. SRA 0x7FFF0000 by 4 -> 0x07FFF000.
- shamt=0, op SLL, data 0xDEADBEEF -> 0xDEADBEEF with latency still 5. Op 11 with data 0x12345678 -> 0x12345678 and out_err=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_data and in_ready=0 all stable. Then raise out_ready with in_valid=1 -> second request accepted on the same edge; next out_valid comes 5 edges later.
- Streaming: issue 4 back-to-back SRA requests with in_valid and out_ready held high -> results are spaced 6 cycles apart, in order, all correct.
- Assert reset_n low at the 3rd SHIFT cycle -> out_valid=0, in_ready=1, out_data=0 immediately (asynchronous). The aborted request produces no result; a fresh SRL 0xF0000000 by 4 after release -> 0x0F000000.
